// File: rtl/ysyx_22051013_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline write-back and
// the mul/div unit, buffering displaced mul/div results in a 2-entry FIFO.
module ysyx_22051013_wb_arbiter #(
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_valid,
  input  logic [4:0]    pipe_rd,
  input  logic [DW-1:0] pipe_data,
  output logic          pipe_stall,
  input  logic          md_valid,
  input  logic [4:0]    md_rd,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  output logic          rf_wen,
  output logic [4:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  typedef enum logic {ARB, FORCE} state_t;

  localparam logic [7:0] AGE_MAX = 8'(STARVE_LIMIT);

  state_t state, state_next;

  logic          ent_valid  [2];
  logic          ent_killed [2];
  logic [4:0]    ent_rd     [2];
  logic [DW-1:0] ent_data   [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count, count_next;
  logic [7:0]    age;

  logic          head_valid, pipe_acc, md_acc, pop, bypass, push, starved;
  logic          win, win_wen;
  logic [4:0]    win_rd;
  logic [DW-1:0] win_data;

  assign md_ready   = (count != 2'd2);
  assign pipe_stall = (state == FORCE);

  // Grant decision; in FORCE pipe_acc is low, so the head pops whenever it exists.
  always_comb begin
    head_valid = (count != 2'd0);
    pipe_acc   = pipe_valid && (state == ARB);
    md_acc     = md_valid && md_ready;
    pop        = head_valid && !pipe_acc;
    bypass     = md_acc && !pipe_acc && !head_valid && (state == ARB);
    push       = md_acc && !bypass && (md_rd != 5'd0) &&
                 !(pipe_acc && (md_rd == pipe_rd));
    count_next = count + {1'b0, push} - {1'b0, pop};
    starved    = head_valid && !pop && (age == AGE_MAX);

    win      = 1'b0;
    win_wen  = 1'b0;
    win_rd   = 5'd0;
    win_data = '0;
    if (pipe_acc) begin
      win      = 1'b1;
      win_wen  = (pipe_rd != 5'd0);
      win_rd   = pipe_rd;
      win_data = pipe_data;
    end else if (pop) begin
      win      = 1'b1;
      win_wen  = !ent_killed[rd_ptr] && (ent_rd[rd_ptr] != 5'd0);
      win_rd   = ent_rd[rd_ptr];
      win_data = ent_data[rd_ptr];
    end else if (bypass) begin
      win      = 1'b1;
      win_wen  = (md_rd != 5'd0);
      win_rd   = md_rd;
      win_data = md_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (starved) state_next = FORCE;
      FORCE:   if (count_next == 2'd0) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_next;
  end

  // A younger pipeline write to the same rd invalidates older buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_killed[i] <= 1'b0;
        ent_rd[i]     <= 5'd0;
        ent_data[i]   <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      age    <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pipe_acc && (pipe_rd != 5'd0) && ent_valid[i] && (ent_rd[i] == pipe_rd))
          ent_killed[i] <= 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr]  <= 1'b1;
        ent_killed[wr_ptr] <= 1'b0;
        ent_rd[wr_ptr]     <= md_rd;
        ent_data[wr_ptr]   <= md_data;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
      end
      count <= count_next;
      if (pop || !head_valid)  age <= 8'd0;
      else if (age != AGE_MAX) age <= age + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= win_wen;
      if (win) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_wb_arbiter.sv
// Directed-vector bench for the write-back arbiter: one table of single-cycle
// vectors plus hand-written starvation and mid-operation reset sequences.
module tb_ysyx_22051013_wb_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_valid;
  logic [4:0]    pipe_rd;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          md_valid;
  logic [4:0]    md_rd;
  logic [DW-1:0] md_data;
  logic          md_ready;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  ysyx_22051013_wb_arbiter #(.DW(DW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pv;
    logic [4:0]    prd;
    logic [DW-1:0] pdata;
    logic          mv;
    logic [4:0]    mrd;
    logic [DW-1:0] mdata;
    logic          stall;
    logic          ready;
    logic          wen;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [DW-1:0] pdata,
                              logic mv, logic [4:0] mrd, logic [DW-1:0] mdata,
                              logic stall, logic ready,
                              logic wen, logic [4:0] waddr, logic [DW-1:0] wdata);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pdata = pdata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.stall = stall; v.ready = ready;
    v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1ns after a rising edge; combinational outputs are
  // sampled on the falling edge, registered outputs 1ns after the next rise.
  task automatic apply_stimulus(input vec_t v, input string tag);
    pipe_valid = v.pv; pipe_rd = v.prd; pipe_data = v.pdata;
    md_valid   = v.mv; md_rd   = v.mrd; md_data   = v.mdata;
    @(negedge clk);
    check_output({tag, " pipe_stall"}, DW'(pipe_stall), DW'(v.stall));
    check_output({tag, " md_ready"},   DW'(md_ready),   DW'(v.ready));
    @(posedge clk);
    #1;
    check_output({tag, " rf_wen"}, DW'(rf_wen), DW'(v.wen));
    if (v.wen) begin
      check_output({tag, " rf_waddr"}, DW'(rf_waddr), DW'(v.waddr));
      check_output({tag, " rf_wdata"}, rf_wdata, v.wdata);
    end
  endtask

  // Pipe writes rd=20 every cycle; md results rd=13/14 arrive in cycles 0 and 1.
  // The head ages to 8 by cycle 9, so cycles 10 and 11 are forced drains.
  task automatic starve_cycles(input int n, input string tag);
    vec_t v;
    for (int c = 0; c < n; c++) begin
      v = mk(1'b1, 5'd20, DW'(c), (c < 2), 5'(13 + c), DW'(64'hD1 + c),
             (c == 10 || c == 11), (c < 2 || c >= 11),
             1'b1, 5'd20, DW'(c));
      if (c == 10) begin v.waddr = 5'd13; v.wdata = 64'hD1; end
      if (c == 11) begin v.waddr = 5'd14; v.wdata = 64'hD2; end
      apply_stimulus(v, $sformatf("%s c%0d", tag, c));
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 0,  0,      1, 5,  'hAA, 0, 1, 1, 5,  'hAA);
    vecs[1]  = mk(1, 3,  'h11,   1, 4,  'h22, 0, 1, 1, 3,  'h11);
    vecs[2]  = mk(0, 0,  0,      0, 0,  0,    0, 1, 1, 4,  'h22);
    vecs[3]  = mk(0, 0,  0,      0, 0,  0,    0, 1, 0, 0,  0);
    vecs[4]  = mk(1, 1,  'h100,  1, 8,  'h80, 0, 1, 1, 1,  'h100);
    vecs[5]  = mk(1, 2,  'h200,  1, 9,  'h90, 0, 1, 1, 2,  'h200);
    vecs[6]  = mk(1, 10, 'hA0,   1, 11, 'hB0, 0, 0, 1, 10, 'hA0);
    vecs[7]  = mk(0, 0,  0,      1, 11, 'hB0, 0, 0, 1, 8,  'h80);
    vecs[8]  = mk(0, 0,  0,      1, 11, 'hB0, 0, 1, 1, 9,  'h90);
    vecs[9]  = mk(0, 0,  0,      0, 0,  0,    0, 1, 1, 11, 'hB0);
    vecs[10] = mk(0, 0,  0,      0, 0,  0,    0, 1, 0, 0,  0);
    vecs[11] = mk(1, 6,  'h66,   1, 7,  'h77, 0, 1, 1, 6,  'h66);
    vecs[12] = mk(1, 7,  'h33,   0, 0,  0,    0, 1, 1, 7,  'h33);
    vecs[13] = mk(0, 0,  0,      1, 0,  'h55, 0, 1, 0, 0,  0);
    vecs[14] = mk(0, 0,  0,      1, 0,  'h55, 0, 1, 0, 0,  0);
    vecs[15] = mk(1, 12, 'hC0,   1, 12, 'hD0, 0, 1, 1, 12, 'hC0);
    vecs[16] = mk(0, 0,  0,      0, 0,  0,    0, 1, 0, 0,  0);
    vecs[17] = mk(1, 0,  'hFF,   0, 0,  0,    0, 1, 0, 0,  0);
    vecs[18] = mk(0, 0,  0,      0, 0,  0,    0, 1, 0, 0,  0);

    rst = 1'b1;
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset rf_wen",     DW'(rf_wen),     0);
    check_output("reset rf_waddr",   DW'(rf_waddr),   0);
    check_output("reset rf_wdata",   rf_wdata,        0);
    check_output("reset pipe_stall", DW'(pipe_stall), 0);
    check_output("reset md_ready",   DW'(md_ready),   1);
    rst = 1'b0;

    for (int i = 0; i < 19; i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    starve_cycles(13, "starve");
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "starve idle");

    starve_cycles(10, "prereset");
    rst = 1'b1;
    pipe_valid = 1'b1; pipe_rd = 5'd20; pipe_data = 64'h99;
    md_valid = 1'b0;
    @(negedge clk);
    check_output("prereset pipe_stall", DW'(pipe_stall), 1);
    check_output("prereset md_ready",   DW'(md_ready),   0);
    @(posedge clk);
    #1;
    check_output("midreset rf_wen",     DW'(rf_wen),     0);
    check_output("midreset pipe_stall", DW'(pipe_stall), 0);
    check_output("midreset md_ready",   DW'(md_ready),   1);
    rst = 1'b0;
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "postreset idle0");
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "postreset idle1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
